muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the multicycle core. It sits directly downstream of the register file. Its operands are `read_data_1` and `read_data_2` as captured by the control FSM, and its `result` goes to the writeback mux feeding `write_data`. It implements all eight M-extension operations with a shared 32-iteration shift datapath, under a start/busy/done handshake that the multicycle controller waits on.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_sign.sv | 12 +
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned MULDIV_ITER  = 32;
    localparam int unsigned MULDIV_CNT_W = 6;

    localparam logic [31:0] MULDIV_DIV0_Q   = 32'hFFFF_FFFF;
    localparam logic [31:0] MULDIV_OVF_Q    = 32'h8000_0000;
    localparam logic [31:0] MULDIV_OVF_R    = 32'h0000_0000;
    localparam logic [31:0] MULDIV_INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] MULDIV_MINUS_1  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_sign.sv
// Conditional two's-complement negate; doubles as absolute value when i_neg is the sign bit.
module muldiv_sign #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val_c
);

    assign o_val_c = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shared 32-step shift datapath behind a start/busy/done handshake.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned DW = 2 * WIDTH;

    muldiv_state_e             r_state;
    muldiv_state_e             w_state_nxt;
    muldiv_op_e                w_op;
    muldiv_op_e                r_op;
    logic                      w_accept;
    logic                      w_a_neg;
    logic                      w_b_neg;
    logic                      w_neg;
    logic                      w_div0;
    logic                      w_ovf;
    logic                      w_special;
    logic [WIDTH-1:0]          w_special_res;
    logic [WIDTH-1:0]          w_abs_a;
    logic [WIDTH-1:0]          w_abs_b;
    logic [MULDIV_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]          r_a;
    logic [WIDTH-1:0]          r_b;
    logic [WIDTH-1:0]          r_rem;
    logic [DW-1:0]             r_acc;
    logic                      r_neg;
    logic                      r_busy;
    logic                      r_done;
    logic [WIDTH-1:0]          r_result;
    logic [WIDTH:0]            w_mul_sum;
    logic [WIDTH:0]            w_rem_sh;
    logic [WIDTH:0]            w_trial;
    logic [DW-1:0]             w_fix_in;
    logic [DW-1:0]             w_fix_out;
    logic [WIDTH-1:0]          w_fix_res;

    assign w_op = muldiv_op_e'(funct3);

    // Operand sign conditioning and special-case detection at accept
    always_comb begin
        w_a_neg       = op_a[WIDTH-1] & (w_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        w_b_neg       = op_b[WIDTH-1] & (w_op inside {OP_MULH, OP_DIV, OP_REM});
        w_neg         = (w_op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_div0        = w_op[2] && (op_b == '0);
        w_ovf         = (w_op inside {OP_DIV, OP_REM}) && (op_a == MULDIV_INT_MIN)
                        && (op_b == MULDIV_MINUS_1);
        w_special     = w_div0 | w_ovf;
        w_special_res = '0;
        if (w_div0) begin
            w_special_res = w_op[1] ? op_a : MULDIV_DIV0_Q;
        end else if (w_ovf) begin
            w_special_res = w_op[1] ? MULDIV_OVF_R : MULDIV_OVF_Q;
        end
    end

    muldiv_sign #(.W(WIDTH)) u_abs_a (.i_val(op_a), .i_neg(w_a_neg), .o_val_c(w_abs_a));
    muldiv_sign #(.W(WIDTH)) u_abs_b (.i_val(op_b), .i_neg(w_b_neg), .o_val_c(w_abs_b));
    muldiv_sign #(.W(DW))    u_fix   (.i_val(w_fix_in), .i_neg(r_neg), .o_val_c(w_fix_out));

    // One shift-add / restoring-subtract step, plus the FIX-stage selection
    always_comb begin
        w_mul_sum = {1'b0, r_acc[DW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
        w_rem_sh  = {r_rem, r_acc[WIDTH-1]};
        w_trial   = w_rem_sh - {1'b0, r_b};
        w_fix_in  = r_acc;
        if (r_op[2]) begin
            w_fix_in = {{WIDTH{1'b0}}, (r_op[1] ? r_rem : r_acc[WIDTH-1:0])};
        end
        w_fix_res = w_fix_out[DW-1:WIDTH];
        if ((r_op == OP_MUL) || r_op[2]) begin
            w_fix_res = w_fix_out[WIDTH-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == MULDIV_CNT_W'(MULDIV_ITER - 1)) begin
                    w_state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_special ? ST_DONE : ST_CALC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_CALC) || (w_state_nxt == ST_FIX);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Datapath registers: load on accept, iterate in CALC, correct sign in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_MUL;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op  <= w_op;
            r_cnt <= '0;
            r_a   <= w_abs_a;
            r_b   <= w_abs_b;
            r_rem <= '0;
            r_neg <= w_neg;
            r_acc <= {{WIDTH{1'b0}}, (w_op[2] ? w_abs_a : w_abs_b)};
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if (r_state == ST_CALC) begin
            r_cnt <= r_cnt + MULDIV_CNT_W'(1);
            if (!r_op[2]) begin
                r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            end else if (!w_trial[WIDTH]) begin
                r_rem              <= w_trial[WIDTH-1:0];
                r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], 1'b1};
            end else begin
                r_rem              <= w_rem_sh[WIDTH-1:0];
                r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], 1'b0};
            end
        end else if (r_state == ST_FIX) begin
            r_result <= w_fix_res;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors, monitor checks result, latency and busy span.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        bit          sp;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   busy_cnt  = 0;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    m_e = sb.pop_front();
                    chk("result", result, m_e.res);
                    chk("done_latency", 32'(cyc - m_e.acc), m_e.sp ? 32'd0 : 32'd33);
                    chk("busy_cycles", 32'(busy_cnt), m_e.sp ? 32'd0 : 32'd33);
                    chk("busy_in_done", 32'(busy), 32'd0);
                end
                busy_cnt = 0;
            end
        end
    end

    // Drive one request; caller positions us before the sampling edge
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit sp);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{exp, sp, cyc});
        start  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout_done", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("timeout_b2b", 32'd0, 32'd1);
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit sp);
        @(negedge clk);
        issue(f, a, b, exp, sp);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        funct3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        rst_n = 1'b1;

        run(F_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run(F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run(F_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        run(F_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run(F_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run(F_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
        run(F_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0);
        run(F_DIVU,   32'd100,        32'd7,         32'd14,        1'b0);
        run(F_REMU,   32'd100,        32'd7,         32'd2,         1'b0);

        // Reset during CALC iteration 10: everything clears immediately
        @(negedge clk);
        issue(F_MUL, 32'h1234, 32'h10, 32'h12340, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_result", result, 32'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(F_MULHU, 32'd3, 32'd5, 32'd0,  1'b0);
        run(F_MUL,   32'd3, 32'd5, 32'd15, 1'b0);

        // Special cases bypass CALC/FIX
        run(F_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1);
        run(F_REM,  32'd5,         32'd0,         32'd5,         1'b1);
        run(F_DIVU, 32'd9,         32'd0,         32'hFFFF_FFFF, 1'b1);
        run(F_REMU, 32'd9,         32'd0,         32'd9,         1'b1);
        run(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run(F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1);

        // Start pulsed mid-CALC with new operands is ignored
        @(negedge clk);
        issue(F_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
        repeat (4) @(negedge clk);
        funct3 = F_MUL;
        op_a   = 32'd2;
        op_b   = 32'd3;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_idle();

        // Operand change mid-CALC has no effect
        @(negedge clk);
        issue(F_MUL, 32'd6, 32'd7, 32'd42, 1'b0);
        repeat (8) @(negedge clk);
        op_a = 32'd1000;
        op_b = 32'd55;
        wait_idle();

        // Back-to-back: start during DONE accepted with no idle cycle
        @(negedge clk);
        issue(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        wait_done();
        issue(F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        wait_done();
        issue(F_REMU, 32'd5, 32'd0, 32'd5, 1'b1);
        wait_done();
        issue(F_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        wait_idle();

        repeat (3) @(negedge clk);
        chk("final_idle_busy", 32'(busy), 32'd0);
        chk("final_idle_done", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
